// File: rtl/axioma_io_pkg.sv
// Shared encodings for the AVR I/O bus initiator: request ops, FSM states and
// the responder address windows (listed in decode priority order).
package axioma_io_pkg;

  typedef enum logic [1:0] {
    OpRead  = 2'b00,
    OpWrite = 2'b01,
    OpSbi   = 2'b10,
    OpCbi   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StAccess,
    StRmwWr,
    StResp
  } state_e;

  localparam int unsigned NumSlaves = 3;
  localparam int unsigned SlvGpio   = 0;
  localparam int unsigned SlvUart   = 1;
  localparam int unsigned SlvTimer0 = 2;

  // Windows overlap; the lowest slave index wins.
  localparam int unsigned WinLo [NumSlaves] = '{SlvGpio: 32'h23, SlvUart: 32'h00, SlvTimer0: 32'h15};
  localparam int unsigned WinHi [NumSlaves] = '{SlvGpio: 32'h2B, SlvUart: 32'h06, SlvTimer0: 32'h2E};

endpackage

// File: rtl/axioma_io_if.sv
// Core request/response channel plus the peripheral I/O bus, bundled for the
// initiator (master modport) and its environment (slave modport).
interface axioma_io_if #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned NUM_SLAVES = 3
);
  import axioma_io_pkg::*;

  logic                         cpu_req_valid;
  logic                         cpu_req_ready;
  op_e                          cpu_req_op;
  logic [ADDR_W-1:0]            cpu_req_addr;
  logic [DATA_W-1:0]            cpu_req_wdata;
  logic [2:0]                   cpu_req_bit;
  logic                         cpu_rsp_valid;
  logic [DATA_W-1:0]            cpu_rsp_rdata;
  logic                         cpu_rsp_err;
  logic [ADDR_W-1:0]            io_addr;
  logic [DATA_W-1:0]            io_wdata;
  logic                         io_read;
  logic                         io_write;
  logic [NUM_SLAVES-1:0]        io_sel;
  logic [NUM_SLAVES*DATA_W-1:0] io_rdata_bus;
  logic                         io_wait;

  modport master (
    input  cpu_req_valid, cpu_req_op, cpu_req_addr, cpu_req_wdata, cpu_req_bit,
    output cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_err,
    output io_addr, io_wdata, io_read, io_write, io_sel,
    input  io_rdata_bus, io_wait
  );

  modport slave (
    output cpu_req_valid, cpu_req_op, cpu_req_addr, cpu_req_wdata, cpu_req_bit,
    input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_err,
    input  io_addr, io_wdata, io_read, io_write, io_sel,
    output io_rdata_bus, io_wait
  );

endinterface

// File: rtl/axioma_io_decode.sv
// Combinational I/O address decode: first matching window gives a one-hot
// select; hit is low for unmapped addresses.
module axioma_io_decode
  import axioma_io_pkg::*;
#(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned NUM_SLAVES = 3
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  hit
);

  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!hit && (32'(addr) >= WinLo[i]) && (32'(addr) <= WinHi[i])) begin
        sel[i] = 1'b1;
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axioma_io_master.sv
// AVR I/O bus initiator: one request at a time, SBI/CBI done as internal
// read-modify-write. Optional io_wait timeout under AXIOMA_IO_TIMEOUT_EN.
module axioma_io_master
  import axioma_io_pkg::*;
#(
  parameter int unsigned ADDR_W         = 6,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned NUM_SLAVES     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input logic         clk,
  input logic         reset,
  axioma_io_if.master bus
);

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [2:0]            bit_q, bit_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic                  err_q, err_d;

  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_hit;
  logic [DATA_W-1:0]     slave_rdata;
  logic [DATA_W-1:0]     bit_mask;
  logic [DATA_W-1:0]     rmw_wdata;
  logic                  is_rmw;
  logic                  timed_out;

  // The wait counter is 4 bits wide.
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 16) begin : g_bad_timeout_cfg
    $error("TIMEOUT_CYCLES must be in 1..16");
  end

  axioma_io_decode #(
    .ADDR_W    (ADDR_W),
    .NUM_SLAVES(NUM_SLAVES)
  ) u_decode (
    .addr(bus.cpu_req_addr),
    .sel (dec_sel),
    .hit (dec_hit)
  );

  always_comb begin
    slave_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) slave_rdata = slave_rdata | bus.io_rdata_bus[i*DATA_W +: DATA_W];
    end
  end

  assign is_rmw    = (op_q == OpSbi) || (op_q == OpCbi);
  assign bit_mask  = DATA_W'(1) << bit_q;
  assign rmw_wdata = (op_q == OpSbi) ? (rdata_q | bit_mask) : (rdata_q & ~bit_mask);

`ifdef AXIOMA_IO_TIMEOUT_EN
  localparam logic [3:0] WaitLast = 4'(TIMEOUT_CYCLES - 1);

  logic [3:0] wait_cnt_q, wait_cnt_d;

  // Leaving a strobe phase always happens with io_wait low, so this also clears per phase.
  assign wait_cnt_d = ((state_q == StAccess || state_q == StRmwWr) && bus.io_wait) ?
                      wait_cnt_q + 4'd1 : 4'd0;
  assign timed_out  = bus.io_wait && (wait_cnt_q == WaitLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_cnt_q <= 4'd0;
    else       wait_cnt_q <= wait_cnt_d;
  end
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    bit_d   = bit_q;
    sel_d   = sel_q;
    err_d   = err_q;

    bus.cpu_req_ready = 1'b0;
    bus.cpu_rsp_valid = 1'b0;
    bus.cpu_rsp_rdata = '0;
    bus.cpu_rsp_err   = 1'b0;
    bus.io_addr       = '0;
    bus.io_wdata      = '0;
    bus.io_read       = 1'b0;
    bus.io_write      = 1'b0;
    bus.io_sel        = '0;

    unique case (state_q)
      StInit: state_d = StIdle;

      StIdle: begin
        bus.cpu_req_ready = 1'b1;
        if (bus.cpu_req_valid) begin
          op_d    = bus.cpu_req_op;
          addr_d  = bus.cpu_req_addr;
          wdata_d = bus.cpu_req_wdata;
          bit_d   = bus.cpu_req_bit;
          sel_d   = dec_sel;
          rdata_d = '0;
          err_d   = !dec_hit;
          state_d = dec_hit ? StAccess : StResp;
        end
      end

      StAccess: begin
        bus.io_addr = addr_q;
        bus.io_sel  = sel_q;
        if (op_q == OpWrite) begin
          bus.io_write = 1'b1;
          bus.io_wdata = wdata_q;
        end else begin
          bus.io_read = 1'b1;
        end
        if (!bus.io_wait) begin
          if (op_q != OpWrite) rdata_d = slave_rdata;
          state_d = is_rmw ? StRmwWr : StResp;
        end else if (timed_out) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StResp;
        end
      end

      StRmwWr: begin
        bus.io_addr  = addr_q;
        bus.io_sel   = sel_q;
        bus.io_write = 1'b1;
        bus.io_wdata = rmw_wdata;
        if (!bus.io_wait) begin
          state_d = StResp;
        end else if (timed_out) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StResp;
        end
      end

      StResp: begin
        bus.cpu_rsp_valid = 1'b1;
        bus.cpu_rsp_rdata = rdata_q;
        bus.cpu_rsp_err   = err_q;
        state_d           = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StInit;
      op_q    <= OpRead;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      bit_q   <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      bit_q   <= bit_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_axioma_io_master.sv
// Directed table-driven bench for axioma_io_master; io_wait expectations follow
// AXIOMA_IO_TIMEOUT_EN.
module tb_axioma_io_master;
  import axioma_io_pkg::*;

  localparam int unsigned ADDR_W         = 6;
  localparam int unsigned DATA_W         = 8;
  localparam int unsigned NUM_SLAVES     = 3;
  localparam int unsigned TIMEOUT_CYCLES = 15;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  axioma_io_if #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .NUM_SLAVES(NUM_SLAVES)
  ) bus_if ();

  axioma_io_master #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .NUM_SLAVES    (NUM_SLAVES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    op_e        op;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [2:0] bitn;
    logic [7:0] gpio;
    logic [7:0] uart;
    logic [7:0] timer;
    int         hold;
    logic [2:0] e_sel;
    int         e_reads;
    int         e_writes;
    logic [7:0] e_wlast;
    logic [7:0] e_rdata;
    logic       e_err;
    int         e_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int         reads, writes, sel_bad, both, rsp_cnt, rsp_lat, rdy_in_rsp, n;
    logic [7:0] wlast, rdata;
    logic       err;
    reads = 0; writes = 0; sel_bad = 0; both = 0; rsp_cnt = 0; rsp_lat = 0; rdy_in_rsp = 0;
    wlast = 8'h00; rdata = 8'h00; err = 1'b0;
    bus_if.io_rdata_bus = {v.timer, v.uart, v.gpio};
    bus_if.io_wait      = (v.hold > 0);
    n = 0;
    while (!bus_if.cpu_req_ready && n < 10) begin
      tick();
      n++;
    end
    chk("ready_before", idx, 32'(bus_if.cpu_req_ready), 32'd1);
    bus_if.cpu_req_valid = 1'b1;
    bus_if.cpu_req_op    = v.op;
    bus_if.cpu_req_addr  = v.addr;
    bus_if.cpu_req_wdata = v.wdata;
    bus_if.cpu_req_bit   = v.bitn;
    tick();
    bus_if.cpu_req_valid = 1'b0;
    for (int lat = 1; lat <= 40; lat++) begin
      if (bus_if.io_read) begin
        reads++;
        if (bus_if.io_sel !== v.e_sel || bus_if.io_addr !== v.addr) sel_bad++;
      end
      if (bus_if.io_write) begin
        writes++;
        wlast = bus_if.io_wdata;
        if (bus_if.io_sel !== v.e_sel || bus_if.io_addr !== v.addr) sel_bad++;
      end
      if (bus_if.io_read && bus_if.io_write) both++;
      if (bus_if.cpu_rsp_valid) begin
        rsp_cnt++;
        if (bus_if.cpu_req_ready) rdy_in_rsp++;
        if (rsp_lat == 0) begin
          rsp_lat = lat;
          rdata   = bus_if.cpu_rsp_rdata;
          err     = bus_if.cpu_rsp_err;
        end
      end
      if (lat == v.hold) bus_if.io_wait = 1'b0;
      tick();
    end
    bus_if.io_wait = 1'b0;
    chk("rsp_count", idx, rsp_cnt, 1);
    chk("rsp_latency", idx, rsp_lat, v.e_lat);
    chk("rsp_rdata", idx, 32'(rdata), 32'(v.e_rdata));
    chk("rsp_err", idx, 32'(err), 32'(v.e_err));
    chk("read_strobes", idx, reads, v.e_reads);
    chk("write_strobes", idx, writes, v.e_writes);
    chk("write_data", idx, 32'(wlast), 32'(v.e_wlast));
    chk("sel_addr_bad", idx, sel_bad, 0);
    chk("both_strobes", idx, both, 0);
    chk("ready_in_rsp", idx, rdy_in_rsp, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rsp_seen;

    //            op       addr   wdata  bit   gpio   uart   timer  hold sel     rd wr wlast  rdata  err lat
    vecs.push_back('{OpRead,  6'h25, 8'h00, 3'd0, 8'h5A, 8'h00, 8'h00, 0, 3'b001, 1, 0, 8'h00, 8'h5A, 1'b0, 2});
    vecs.push_back('{OpWrite, 6'h06, 8'hC3, 3'd0, 8'h00, 8'h77, 8'h00, 0, 3'b010, 0, 1, 8'hC3, 8'h00, 1'b0, 2});
    vecs.push_back('{OpSbi,   6'h2C, 8'h00, 3'd3, 8'h00, 8'h00, 8'h81, 0, 3'b100, 1, 1, 8'h89, 8'h81, 1'b0, 3});
    vecs.push_back('{OpCbi,   6'h2C, 8'h00, 3'd0, 8'h00, 8'h00, 8'h81, 0, 3'b100, 1, 1, 8'h80, 8'h81, 1'b0, 3});
    vecs.push_back('{OpRead,  6'h3F, 8'h00, 3'd0, 8'hAA, 8'hAA, 8'hAA, 0, 3'b000, 0, 0, 8'h00, 8'h00, 1'b1, 1});
    vecs.push_back('{OpRead,  6'h2B, 8'h00, 3'd0, 8'h11, 8'h00, 8'h99, 0, 3'b001, 1, 0, 8'h00, 8'h11, 1'b0, 2});
    vecs.push_back('{OpRead,  6'h2C, 8'h00, 3'd0, 8'h11, 8'h00, 8'h3C, 0, 3'b100, 1, 0, 8'h00, 8'h3C, 1'b0, 2});
    vecs.push_back('{OpRead,  6'h22, 8'h00, 3'd0, 8'h11, 8'h22, 8'h4D, 0, 3'b100, 1, 0, 8'h00, 8'h4D, 1'b0, 2});
    vecs.push_back('{OpRead,  6'h23, 8'h00, 3'd0, 8'hE1, 8'h22, 8'h99, 0, 3'b001, 1, 0, 8'h00, 8'hE1, 1'b0, 2});
    vecs.push_back('{OpRead,  6'h00, 8'h00, 3'd0, 8'h11, 8'h5F, 8'h99, 0, 3'b010, 1, 0, 8'h00, 8'h5F, 1'b0, 2});
    vecs.push_back('{OpRead,  6'h07, 8'h00, 3'd0, 8'h11, 8'h5F, 8'h99, 0, 3'b000, 0, 0, 8'h00, 8'h00, 1'b1, 1});
    vecs.push_back('{OpRead,  6'h14, 8'h00, 3'd0, 8'h11, 8'h5F, 8'h99, 0, 3'b000, 0, 0, 8'h00, 8'h00, 1'b1, 1});
    vecs.push_back('{OpRead,  6'h15, 8'h00, 3'd0, 8'h11, 8'h5F, 8'h2A, 0, 3'b100, 1, 0, 8'h00, 8'h2A, 1'b0, 2});
    vecs.push_back('{OpRead,  6'h2E, 8'h00, 3'd0, 8'h11, 8'h5F, 8'h71, 0, 3'b100, 1, 0, 8'h00, 8'h71, 1'b0, 2});
    vecs.push_back('{OpRead,  6'h2F, 8'h00, 3'd0, 8'h11, 8'h5F, 8'h71, 0, 3'b000, 0, 0, 8'h00, 8'h00, 1'b1, 1});
    vecs.push_back('{OpSbi,   6'h05, 8'h00, 3'd7, 8'h00, 8'h01, 8'h00, 0, 3'b010, 1, 1, 8'h81, 8'h01, 1'b0, 3});
    vecs.push_back('{OpCbi,   6'h24, 8'h00, 3'd7, 8'hFF, 8'h00, 8'h00, 0, 3'b001, 1, 1, 8'h7F, 8'hFF, 1'b0, 3});
    vecs.push_back('{OpSbi,   6'h30, 8'h00, 3'd2, 8'h55, 8'h55, 8'h55, 0, 3'b000, 0, 0, 8'h00, 8'h00, 1'b1, 1});
    vecs.push_back('{OpWrite, 6'h3F, 8'h12, 3'd0, 8'h55, 8'h55, 8'h55, 0, 3'b000, 0, 0, 8'h00, 8'h00, 1'b1, 1});
`ifdef AXIOMA_IO_TIMEOUT_EN
    vecs.push_back('{OpRead,  6'h25, 8'h00, 3'd0, 8'h5A, 8'h00, 8'h00, 20, 3'b001, 15, 0, 8'h00, 8'h00, 1'b1, 16});
    vecs.push_back('{OpSbi,   6'h2C, 8'h00, 3'd1, 8'h00, 8'h00, 8'h81, 20, 3'b100, 15, 0, 8'h00, 8'h00, 1'b1, 16});
`else
    vecs.push_back('{OpRead,  6'h25, 8'h00, 3'd0, 8'h5A, 8'h00, 8'h00, 20, 3'b001, 20, 0, 8'h00, 8'h5A, 1'b0, 21});
    vecs.push_back('{OpSbi,   6'h2C, 8'h00, 3'd1, 8'h00, 8'h00, 8'h81, 3, 3'b100, 3, 1, 8'h83, 8'h81, 1'b0, 5});
`endif

    reset                = 1'b1;
    bus_if.cpu_req_valid = 1'b0;
    bus_if.cpu_req_op    = OpRead;
    bus_if.cpu_req_addr  = '0;
    bus_if.cpu_req_wdata = '0;
    bus_if.cpu_req_bit   = '0;
    bus_if.io_rdata_bus  = '0;
    bus_if.io_wait       = 1'b0;
    tick();
    tick();
    chk("rst_ready", 0, 32'(bus_if.cpu_req_ready), 32'd0);
    chk("rst_rsp_valid", 0, 32'(bus_if.cpu_rsp_valid), 32'd0);
    chk("rst_strobes", 0, 32'({bus_if.io_read, bus_if.io_write}), 32'd0);
    chk("rst_sel", 0, 32'(bus_if.io_sel), 32'd0);
    chk("rst_addr", 0, 32'(bus_if.io_addr), 32'd0);
    reset = 1'b0;
    tick();
    chk("ready_after_rst", 0, 32'(bus_if.cpu_req_ready), 32'd1);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset landing in the RMW write phase.
    bus_if.io_rdata_bus  = {8'h81, 8'h00, 8'h00};
    bus_if.cpu_req_valid = 1'b1;
    bus_if.cpu_req_op    = OpSbi;
    bus_if.cpu_req_addr  = 6'h2C;
    bus_if.cpu_req_bit   = 3'd3;
    tick();
    bus_if.cpu_req_valid = 1'b0;
    chk("rmw_rst_read", 100, 32'(bus_if.io_read), 32'd1);
    tick();
    chk("rmw_rst_write", 100, 32'(bus_if.io_write), 32'd1);
    chk("rmw_rst_wdata", 100, 32'(bus_if.io_wdata), 32'h89);
    reset = 1'b1;
    #1;
    chk("rmw_rst_write_drop", 100, 32'(bus_if.io_write), 32'd0);
    chk("rmw_rst_sel_drop", 100, 32'(bus_if.io_sel), 32'd0);
    chk("rmw_rst_ready", 100, 32'(bus_if.cpu_req_ready), 32'd0);
    rsp_seen = 0;
    for (int k = 0; k < 3; k++) begin
      if (bus_if.cpu_rsp_valid || bus_if.io_write) rsp_seen++;
      tick();
    end
    reset = 1'b0;
    #1;
    chk("rmw_rst_ready_pre_edge", 100, 32'(bus_if.cpu_req_ready), 32'd0);
    tick();
    if (bus_if.cpu_rsp_valid || bus_if.io_write) rsp_seen++;
    chk("rmw_rst_no_rsp", 100, rsp_seen, 0);
    chk("rmw_rst_ready_post", 100, 32'(bus_if.cpu_req_ready), 32'd1);

    run_vec(vecs[0], 101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
